// File: rtl/dm_arbiter.sv
// Data-memory arbiter: shares the single-port data RAM between CPU load/store
// and a loader burst engine, with a bounded-starvation guarantee for the loader.
//
// state | meaning
// IDLE  | no burst; CPU owns the RAM, ld_start accepted
// BURST | loader words outstanding; CPU has priority until starve limit
// DONE  | one-cycle ld_done pulse, then back to IDLE
module dm_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_start,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W-1:0] ld_len,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_rd,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]        state_q;
    logic              dir_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remain_q;
    logic [3:0]        starve_q;
    logic              ld_grant;
    logic              cpu_grant;

    // clr gates the grants so every output is quiet while reset is held
    always_comb begin
        ld_grant  = ~clr & (state_q == S_BURST) & (~cpu_req | (starve_q == STARVE_LIM));
        cpu_grant = ~clr & cpu_req & ~ld_grant;
    end

    always_comb begin
        ram_cs    = 1'b0;
        ram_rd    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        cpu_rdata = '0;
        ld_rdata  = '0;
        ld_ack    = 1'b0;
        ld_rvalid = 1'b0;
        if (cpu_grant) begin
            ram_cs    = 1'b1;
            ram_rd    = ~cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            cpu_rdata = ram_rdata;
        end else if (ld_grant) begin
            ram_cs    = 1'b1;
            ram_rd    = ~dir_q;
            ram_addr  = addr_q;
            ram_wdata = ld_wdata;
            ld_ack    = dir_q;
            ld_rvalid = ~dir_q;
            ld_rdata  = dir_q ? '0 : ram_rdata;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_grant & ~clr;
    assign ld_busy   = (state_q == S_BURST) | (state_q == S_DONE);
    assign ld_done   = (state_q == S_DONE);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            addr_q   <= '0;
            remain_q <= '0;
            starve_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    starve_q <= '0;
                    if (ld_start) begin
                        dir_q    <= ld_we;
                        addr_q   <= ld_base;
                        remain_q <= ld_len;
                        state_q  <= (ld_len == '0) ? S_DONE : S_BURST;
                    end
                end
                S_BURST: begin
                    if (ld_grant) begin
                        addr_q   <= addr_q + ADDR_W'(1);
                        remain_q <= remain_q - ADDR_W'(1);
                        starve_q <= '0;
                        if (remain_q == ADDR_W'(1)) begin
                            state_q <= S_DONE;
                        end
                    end else if (starve_q != STARVE_LIM) begin
                        // loader only loses a BURST cycle to a CPU request
                        starve_q <= starve_q + 4'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: vector table, directed burst corner cases,
// then randomized traffic against a queue-based reference model.
module tb_dm_arbiter;

    localparam int STARVE = 4;

    logic        clk;
    logic        clr;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        ld_start;
    logic        ld_we;
    logic [7:0]  ld_base;
    logic [7:0]  ld_len;
    logic [31:0] ld_wdata;
    logic        ld_ack;
    logic [31:0] ld_rdata;
    logic        ld_rvalid;
    logic        ld_busy;
    logic        ld_done;
    logic [7:0]  ram_addr;
    logic        ram_cs;
    logic        ram_rd;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [256];
    logic [31:0] exp_mem [256];

    int checks = 0;
    int failures = 0;

    dm_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
        .clk(clk), .clr(clr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_start(ld_start), .ld_we(ld_we), .ld_base(ld_base), .ld_len(ld_len),
        .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .ld_rvalid(ld_rvalid), .ld_busy(ld_busy), .ld_done(ld_done),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_rd(ram_rd),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // RAM model: combinational read, write at the edge ending the access
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_cs && !ram_rd) mem[ram_addr] <= ram_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        exp_stall;
        logic        exp_cs;
        logic        exp_rd;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " cpu_rdata"}, cpu_rdata, 0);
        chk({tag, " cpu_stall"}, 32'(cpu_stall), 0);
        chk({tag, " ld_ack"}, 32'(ld_ack), 0);
        chk({tag, " ld_rdata"}, ld_rdata, 0);
        chk({tag, " ld_rvalid"}, 32'(ld_rvalid), 0);
        chk({tag, " ld_busy"}, 32'(ld_busy), 0);
        chk({tag, " ld_done"}, 32'(ld_done), 0);
        chk({tag, " ram_addr"}, 32'(ram_addr), 0);
        chk({tag, " ram_cs"}, 32'(ram_cs), 0);
        chk({tag, " ram_rd"}, 32'(ram_rd), 0);
        chk({tag, " ram_wdata"}, ram_wdata, 0);
    endtask

    task automatic cpu_store(input logic [7:0] a, input logic [31:0] d);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    // reference model state: outstanding burst addresses in order
    logic [7:0] q[$];
    bit         m_done;
    bit         m_dir;
    int         m_denied;

    initial begin
        bit in_burst, l_turn, c_turn;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata, e_cpu_rd, e_ld_rd;

        vecs[0] = '{1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 8'h10, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b0, 8'h10, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 8'h11, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 8'h11, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b0, 8'h10, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF};

        clr = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h33; cpu_wdata = 32'h1234;
        ld_start = 1'b1; ld_we = 1'b1; ld_base = 8'h5; ld_len = 8'h3; ld_wdata = 32'h77;
        #2 clr = 1'b1;
        #1 chk_quiet("reset_immediate");
        tick(); tick(); tick();
        @(negedge clk);
        chk_quiet("reset_held");
        ld_start = 1'b0; cpu_req = 1'b0;
        tick();
        clr = 1'b0;

        // idle CPU traffic
        for (int i = 0; i < 6; i++) begin
            cpu_req = vecs[i].req; cpu_we = vecs[i].we;
            cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
            @(negedge clk);
            chk($sformatf("vec%0d stall", i), 32'(cpu_stall), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d cs", i), 32'(ram_cs), 32'(vecs[i].exp_cs));
            chk($sformatf("vec%0d rd", i), 32'(ram_rd), 32'(vecs[i].exp_rd));
            if (vecs[i].chk_rdata) chk($sformatf("vec%0d rdata", i), cpu_rdata, vecs[i].exp_rdata);
            tick();
        end
        cpu_req = 1'b0; cpu_we = 1'b0;

        // uncontended write burst wrapping past 0xFF
        ld_start = 1'b1; ld_we = 1'b1; ld_base = 8'hFE; ld_len = 8'd4;
        tick();
        ld_start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            ld_wdata = 32'(k);
            @(negedge clk);
            chk($sformatf("wr_burst ack%0d", k), 32'(ld_ack), 1);
            chk($sformatf("wr_burst addr%0d", k), 32'(ram_addr), 32'(8'(8'hFE + k - 1)));
            chk($sformatf("wr_burst done%0d", k), 32'(ld_done), 0);
            tick();
        end
        @(negedge clk);
        chk("wr_burst done_pulse", 32'(ld_done), 1);
        chk("wr_burst ack_after", 32'(ld_ack), 0);
        tick();
        @(negedge clk);
        chk("wr_burst done_clear", 32'(ld_done), 0);
        chk("wr_burst busy_clear", 32'(ld_busy), 0);
        chk("wr_burst mem_fe", mem[8'hFE], 1);
        chk("wr_burst mem_ff", mem[8'hFF], 2);
        chk("wr_burst mem_00", mem[8'h00], 3);
        chk("wr_burst mem_01", mem[8'h01], 4);

        // starvation bound: read burst under continuous CPU load
        for (int i = 0; i < 8; i++) cpu_store(8'(8'h20 + i), 32'h100 + 32'(i));
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        ld_start = 1'b1; ld_we = 1'b0; ld_base = 8'h20; ld_len = 8'd8;
        @(negedge clk);
        chk("starve start_stall", 32'(cpu_stall), 0);
        tick();
        ld_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk($sformatf("starve stall c%0d", c), 32'(cpu_stall), 32'((c % 5) == 4));
            chk($sformatf("starve rvalid c%0d", c), 32'(ld_rvalid), 32'((c % 5) == 4));
            if ((c % 5) == 4) chk($sformatf("starve rdata c%0d", c), ld_rdata, 32'h100 + 32'(c / 5));
            else              chk($sformatf("starve cpu_rdata c%0d", c), cpu_rdata, 32'hDEADBEEF);
            tick();
        end
        @(negedge clk);
        chk("starve done_pulse", 32'(ld_done), 1);
        chk("starve done_stall", 32'(cpu_stall), 0);
        tick();
        cpu_req = 1'b0;

        // empty burst
        ld_start = 1'b1; ld_we = 1'b1; ld_base = 8'h90; ld_len = 8'd0;
        tick();
        ld_start = 1'b0;
        @(negedge clk);
        chk("empty done", 32'(ld_done), 1);
        chk("empty cs", 32'(ram_cs), 0);
        tick();
        @(negedge clk);
        chk("empty done_clear", 32'(ld_done), 0);
        chk("empty busy_clear", 32'(ld_busy), 0);
        tick();

        // second start during a burst is ignored
        ld_start = 1'b1; ld_we = 1'b1; ld_base = 8'h40; ld_len = 8'd3;
        tick();
        ld_we = 1'b0; ld_base = 8'h80; ld_len = 8'd7;
        for (int k = 0; k < 3; k++) begin
            ld_wdata = 32'h300 + 32'(k);
            @(negedge clk);
            chk($sformatf("ignore ack%0d", k), 32'(ld_ack), 1);
            chk($sformatf("ignore addr%0d", k), 32'(ram_addr), 32'h40 + 32'(k));
            tick();
        end
        @(negedge clk);
        chk("ignore done", 32'(ld_done), 1);
        tick();
        ld_start = 1'b0;
        @(negedge clk);
        chk("ignore idle", 32'(ld_busy), 0);
        chk("ignore mem40", mem[8'h40], 32'h300);
        chk("ignore mem42", mem[8'h42], 32'h302);
        tick();

        // reset in the middle of a write burst
        for (int i = 0; i < 6; i++) cpu_store(8'(8'h60 + i), 32'h55);
        ld_start = 1'b1; ld_we = 1'b1; ld_base = 8'h60; ld_len = 8'd6;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ld_wdata = 32'hA0 + 32'(k);
            @(negedge clk);
            chk($sformatf("midrst ack%0d", k), 32'(ld_ack), 1);
            tick();
        end
        ld_wdata = 32'hA2;
        clr = 1'b1;
        #1 chk_quiet("midrst asserted");
        tick(); tick();
        clr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("midrst no_done%0d", c), 32'(ld_done), 0);
            chk($sformatf("midrst no_busy%0d", c), 32'(ld_busy), 0);
            tick();
        end
        chk("midrst mem60", mem[8'h60], 32'hA0);
        chk("midrst mem61", mem[8'h61], 32'hA1);
        for (int i = 2; i < 6; i++) chk($sformatf("midrst mem6%0d", i), mem[8'(8'h60 + i)], 32'h55);
        ld_start = 1'b1; ld_we = 1'b0; ld_base = 8'h60; ld_len = 8'd2;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("midrst reread valid%0d", k), 32'(ld_rvalid), 1);
            chk($sformatf("midrst reread data%0d", k), ld_rdata, 32'hA0 + 32'(k));
            tick();
        end
        @(negedge clk);
        chk("midrst reread done", 32'(ld_done), 1);
        tick();

        // randomized traffic against the reference model
        for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
        q.delete();
        m_done = 1'b0; m_dir = 1'b0; m_denied = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            cpu_req   = ($urandom_range(0, 99) < 55);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 8'($urandom_range(0, 31));
            cpu_wdata = $urandom();
            ld_start  = ($urandom_range(0, 9) == 0);
            ld_we     = 1'($urandom_range(0, 1));
            ld_base   = 8'($urandom_range(0, 255));
            ld_len    = 8'($urandom_range(0, 6));
            ld_wdata  = $urandom();

            in_burst = (q.size() > 0);
            l_turn   = in_burst && (!cpu_req || m_denied == STARVE);
            c_turn   = cpu_req && !l_turn;
            e_addr   = l_turn ? q[0] : (c_turn ? cpu_addr : 8'h0);
            e_wdata  = l_turn ? ld_wdata : (c_turn ? cpu_wdata : 32'h0);
            e_cpu_rd = c_turn ? exp_mem[cpu_addr] : 32'h0;
            e_ld_rd  = (l_turn && !m_dir) ? exp_mem[q[0]] : 32'h0;

            @(negedge clk);
            chk($sformatf("rnd%0d stall", cyc), 32'(cpu_stall), 32'(cpu_req && !c_turn));
            chk($sformatf("rnd%0d cs", cyc), 32'(ram_cs), 32'(l_turn || c_turn));
            chk($sformatf("rnd%0d addr", cyc), 32'(ram_addr), 32'(e_addr));
            chk($sformatf("rnd%0d wdata", cyc), ram_wdata, e_wdata);
            chk($sformatf("rnd%0d rd", cyc), 32'(ram_rd),
                32'((l_turn && !m_dir) || (c_turn && !cpu_we)));
            chk($sformatf("rnd%0d cpu_rdata", cyc), cpu_rdata, e_cpu_rd);
            chk($sformatf("rnd%0d ld_rdata", cyc), ld_rdata, e_ld_rd);
            chk($sformatf("rnd%0d ack", cyc), 32'(ld_ack), 32'(l_turn && m_dir));
            chk($sformatf("rnd%0d rvalid", cyc), 32'(ld_rvalid), 32'(l_turn && !m_dir));
            chk($sformatf("rnd%0d done", cyc), 32'(ld_done), 32'(m_done));
            chk($sformatf("rnd%0d busy", cyc), 32'(ld_busy), 32'(in_burst || m_done));

            if (c_turn && cpu_we) exp_mem[cpu_addr] = cpu_wdata;
            if (l_turn && m_dir)  exp_mem[q[0]] = ld_wdata;
            if (m_done) begin
                m_done = 1'b0;
            end else if (in_burst) begin
                if (l_turn) begin
                    void'(q.pop_front());
                    m_denied = 0;
                    if (q.size() == 0) m_done = 1'b1;
                end else begin
                    m_denied++;
                end
            end else begin
                m_denied = 0;
                if (ld_start) begin
                    m_dir = ld_we;
                    for (int i = 0; i < int'(ld_len); i++) q.push_back(8'(ld_base + i));
                    if (ld_len == 8'd0) m_done = 1'b1;
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Data-memory arbiter and burst sequencer that shares the single-port word-addressed data RAM between the CPU load/store path and a loader/debug port. CPU single-word accesses normally take priority. The loader runs multi-word bursts, read or write, from a base address, and gets a guaranteed slot after a bounded number of denied cycles. The block sits between the CPU datapath (ALU result / register read2) and the `ram` instance. While the CPU's memory access is held off it raises a stall that freezes the PC.

## Interface
Parameters:
- ADDR_W, 8, RAM word-address width (matches ALU result bits [9:2]).
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive denied loader cycles before the loader is forced a grant; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU requests a memory access this cycle (decoded from the control word's mem chip-select).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data, valid in the cycle the CPU is granted.
- cpu_stall  out  1  CPU request present but not granted; holds the PC and blocks register write.
- ld_start  in  1  start a burst; sampled only in IDLE.
- ld_we  in  1  burst direction (1 = write RAM), latched at start.
- ld_base  in  ADDR_W  burst start address, latched at start.
- ld_len  in  ADDR_W  burst length in words, latched at start; 0 = empty burst.
- ld_wdata  in  DATA_W  current write word; the block consumes it on a cycle with ld_ack=1.
- ld_ack  out  1  loader write word consumed this cycle.
- ld_rdata  out  DATA_W  burst read word.
- ld_rvalid  out  1  ld_rdata valid this cycle.
- ld_busy  out  1  burst in progress (BURST or DONE).
- ld_done  out  1  one-cycle pulse at burst completion.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_cs  out  1  to RAM cs.
- ram_rd  out  1  to RAM rd/oe (1 = read).
- ram_wdata  out  DATA_W  to RAM write_data.
- ram_rdata  in  DATA_W  from RAM read_data (combinational read).

## Operation
- FSM states are IDLE, BURST and DONE.
  - IDLE: if ld_start=1, latch ld_we, ld_base and ld_len into dir, addr_q and remain_q. Go to DONE if ld_len=0, otherwise go to BURST.
  - BURST: each loader grant increments addr_q and decrements remain_q. addr_q wraps from 2^ADDR_W−1 to 0. The grant that makes remain_q reach 0 moves the FSM to DONE.
  - DONE: ld_done=1 for one cycle, then IDLE.
- Grant rule, combinational each cycle:
  - In IDLE or DONE, the CPU gets the grant whenever cpu_req=1.
  - In BURST, the loader is granted if cpu_req=0 or starve_q==STARVE_MAX. Otherwise the CPU is granted.
- starve_q counter:
  - Increments by 1 on each BURST cycle where the loader is denied.
  - Clears to 0 on each loader grant and in IDLE.
  - Saturates at STARVE_MAX.
- cpu_stall = cpu_req & ~cpu_grant.
- RAM drive on a CPU grant: ram_cs=1, ram_rd=~cpu_we, ram_addr=cpu_addr, ram_wdata=cpu_wdata, cpu_rdata=ram_rdata.
- RAM drive on a loader grant: ram_cs=1, ram_rd=~dir, ram_addr=addr_q, ram_wdata=ld_wdata.
  - For a write burst, ld_ack=1.
  - For a read burst, ld_rvalid=1 and ld_rdata=ram_rdata.
- No grant: ram_cs=0, ram_rd=0. ram_addr, ram_wdata, cpu_rdata and ld_rdata are 0.
- ld_start in BURST or DONE is ignored, with no effect on latched values.

## Timing
- Reset: while clr=1, and immediately on its assertion, the FSM is IDLE and addr_q, remain_q and starve_q are 0.
  - All outputs are 0, including cpu_stall, which is gated by clr.
- Reset mid-burst: the burst is abandoned and no ld_done pulse is produced. RAM writes already performed stay.
- ld_start high at edge t: BURST from cycle t+1, and the first loader access can occur in cycle t+1.
- Uncontended burst of N words: accesses occur in cycles t+1..t+N, ld_done=1 in cycle t+N+1, IDLE from t+N+2.
- Empty burst (ld_len=0): ld_done=1 in cycle t+1, with no RAM access.
- RAM writes commit at the rising edge that ends the granted cycle. Read data is valid combinationally in the granted cycle.
- Worst-case CPU wait: 1 cycle per STARVE_MAX+1 cycles while a burst is active.
- Worst-case loader wait: STARVE_MAX cycles per word.
- Simultaneous cpu_req and forced loader grant: the loader wins, cpu_stall=1 for that cycle, and the CPU access repeats the next cycle.

## Test plan
- Reset and idle CPU traffic:
  - Assert clr with cpu_req=1: all outputs are 0.
  - Release clr, then a CPU store to addr 0x10 of 0xDEADBEEF followed by a load from 0x10: cpu_stall=0 throughout and cpu_rdata=0xDEADBEEF.
- Uncontended write burst:
  - Stimulus: ld_base=0xFE, ld_len=4, ld_we=1, data 1..4.
  - ld_ack is high for 4 cycles and ld_done pulses in cycle 5.
  - RAM holds 1, 2, 3, 4 at 0xFE, 0xFF, 0x00, 0x01 (wrap-around).
- Starvation bound:
  - Stimulus: STARVE_MAX=4, read burst of 8 words while cpu_req is held at 1.
  - Pattern is 4 CPU grants followed by 1 loader grant, repeating, with cpu_stall=1 exactly on loader-grant cycles.
  - ld_done pulses after 40 cycles.
- Empty burst and ignored start:
  - ld_len=0: ld_done pulses at t+1 with no ram_cs.
  - A second ld_start during a 3-word burst with a different base: the original base and length are kept.
- Reset mid-burst:
  - Assert clr after 2 of 6 words.
  - ld_busy=0 and ld_done never pulses; words 0..1 are written and words 2..5 are unchanged.
  - A new burst starts cleanly afterwards.
